seq_player: RTL and testbench
=============================

# seq_player

Consumes the 18-bit, nine-symbol random sequence produced by the upstream random generator, plays it back one symbol at a time, and checks player key presses against it in rounds of growing length (round r plays and expects symbols 0..r). It sits between the random generator and the LED/HEX display and key-debounce logic of the memory game, and reports progress, win and fail to the top-level game controller.

## Interface
- SHOW_CYCLES, 25000000: cycles a symbol is displayed.
- GAP_CYCLES, 12500000: blank cycles after each displayed symbol.
- TIMEOUT_CYCLES, 250000000: maximum cycles to wait for each key press.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  reset, asynchronous and active-low.
- load  in  1  one-cycle pulse: capture seq_in and start round 0; honoured only in IDLE, WIN or FAIL.
- seq_in  in  18  symbols; symbol k = seq_in[2k+1:2k]; legal values 0..2.
- key_valid  in  1  one-cycle pulse per debounced key press.
- key  in  2  pressed key code, sampled when key_valid=1.
- show_valid  out  1  high while a symbol is displayed.
- show_sym  out  2  symbol being displayed; 0 when show_valid=0.
- round  out  4  current round 0..8; holds its final value in WIN/FAIL.
- busy  out  1  high in every state except IDLE, WIN, FAIL.
- win  out  1  level, high in WIN.
- fail  out  1  level, high in FAIL.

## Operation
- Reset: state IDLE; all outputs 0; seq register 0; timer 0; index 0.
- States: IDLE, SHOW_ON, SHOW_GAP, WAIT_KEY, WIN, FAIL.
- IDLE/WIN/FAIL + load: latch seq_in, round=0, index=0, timer=0 -> SHOW_ON. Otherwise the state holds.
- SHOW_ON: show_valid=1, show_sym=symbol[index]; after SHOW_CYCLES cycles -> SHOW_GAP.
- SHOW_GAP: after GAP_CYCLES cycles: if index==round then index=0 -> WAIT_KEY; else index+1 -> SHOW_ON.
- WAIT_KEY, key_valid with key==symbol[index]:
  - if index<round: index+1; timer restarts.
  - if index==round and round<8: round+1, index=0 -> SHOW_ON.
  - if index==round and round==8: -> WIN.
- WAIT_KEY, key_valid with key!=symbol[index] (key=3 is always a mismatch): -> FAIL.
- WAIT_KEY: no key_valid within TIMEOUT_CYCLES cycles of entering the state or of the last accepted key -> FAIL. If key_valid arrives on the same cycle the timeout expires, the key takes priority.
- key_valid outside WAIT_KEY: ignored.
- load while busy: ignored.
- Symbol value 3 in seq_in: played as-is and can never be matched.
- reset_n low at any time, including mid-show or mid-input: immediate return to the reset state.

## Timing
- All outputs are registered and change one cycle after the causing edge.
- load at edge t: show_valid=1 from t+1 for exactly SHOW_CYCLES cycles, then low for GAP_CYCLES cycles.
- Round r play phase lasts (r+1)·(SHOW_CYCLES+GAP_CYCLES) cycles.
- A correct final key at edge t: show_valid rises at t+1 for the next round, or win rises at t+1 on round 8.
- A wrong key at edge t: fail=1 at t+1.
- Timer: a single down-counter, width $clog2 of the largest parameter, reloaded on every state change.

## Structure
- Shared package seq_pkg holds:
  - the state enum;
  - SEQ_LEN=9 and SYM_W=2;
  - a function extracting symbol k from the 18-bit vector.
- Sub-module cycle_timer, which reloads and signals expiry, is instantiated once. The rest of the logic is a single FSM plus its datapath.

## Test plan
All scenarios use SHOW_CYCLES=3, GAP_CYCLES=2, TIMEOUT_CYCLES=20.
- load with seq_in=18'h0_0000: show_valid high for cycles 1–3 with show_sym=0, then low for 2 cycles; busy=1; state WAIT_KEY reached.
- seq_in=18'b10_01_00_10_01_00_10_01_00, all keys correct every round: round goes 0→8, the 9-symbol play in round 8 matches the sequence, win=1, busy=0.
- Same sequence, round 2, second key=2 (expected 1): fail=1 the next cycle, round stays 2, show_valid=0.
- No key for 20 cycles in WAIT_KEY: fail=1. A key on cycle 19 instead: accepted and the timer restarts.
- reset_n pulsed low mid-SHOW_ON with show_sym=2: all outputs 0 immediately, with no wait for a clock edge. A new load restarts round 0.
- load and key_valid pulsed during SHOW_ON: no effect on state, round or outputs. key=3 in WAIT_KEY: fail=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and helpers for the memory-game sequence player.
package seq_pkg;

  localparam int SEQ_LEN = 9;
  localparam int SYM_W   = 2;
  localparam int SEQ_W   = SEQ_LEN * SYM_W;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ON,
    SHOW_GAP,
    WAIT_KEY,
    WIN,
    FAIL
  } state_t;

  function automatic logic [SYM_W-1:0] sym_at(input logic [SEQ_W-1:0] seq,
                                              input logic [3:0]       k);
    return seq[k*SYM_W +: SYM_W];
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Reloadable down-counter; expired is high while the count sits at zero.
module cycle_timer #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         reload,
  input  logic [W-1:0] reload_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (reload)
      count <= reload_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/seq_player.sv
// Plays a nine-symbol sequence in growing rounds and checks key presses against it.
module seq_player
  import seq_pkg::*;
#(
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [SEQ_W-1:0] seq_in,
  input  logic             key_valid,
  input  logic [1:0]       key,
  output logic             show_valid,
  output logic [1:0]       show_sym,
  output logic [3:0]       round,
  output logic             busy,
  output logic             win,
  output logic             fail
);

  localparam int MAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_P  = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int TW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  state_t           state, state_n;
  logic [SEQ_W-1:0] seq_r, seq_n;
  logic [3:0]       round_n;
  logic [3:0]       index_r, index_n;
  logic [1:0]       cur_sym;
  logic             restart;
  logic             reload;
  logic [TW-1:0]    reload_val;
  logic             expired;

  assign cur_sym = sym_at(seq_r, index_r);

  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .reload     (reload),
    .reload_val (reload_val),
    .expired    (expired)
  );

  always_comb begin
    state_n = state;
    seq_n   = seq_r;
    round_n = round;
    index_n = index_r;
    restart = 1'b0;
    case (state)
      IDLE, WIN, FAIL: begin
        if (load) begin
          seq_n   = seq_in;
          round_n = '0;
          index_n = '0;
          state_n = SHOW_ON;
        end
      end
      SHOW_ON: begin
        if (expired) state_n = SHOW_GAP;
      end
      SHOW_GAP: begin
        if (expired) begin
          if (index_r == round) begin
            index_n = '0;
            state_n = WAIT_KEY;
          end else begin
            index_n = index_r + 4'd1;
            state_n = SHOW_ON;
          end
        end
      end
      WAIT_KEY: begin
        // A key on the expiry cycle wins over the timeout; symbol 3 never matches.
        if (key_valid) begin
          if (key == cur_sym && cur_sym != 2'd3) begin
            if (index_r != round) begin
              index_n = index_r + 4'd1;
              restart = 1'b1;
            end else if (round != 4'(SEQ_LEN - 1)) begin
              round_n = round + 4'd1;
              index_n = '0;
              state_n = SHOW_ON;
            end else begin
              state_n = WIN;
            end
          end else begin
            state_n = FAIL;
          end
        end else if (expired) begin
          state_n = FAIL;
        end
      end
      default: state_n = IDLE;
    endcase

    reload = (state_n != state) || restart;
    case (state_n)
      SHOW_ON:  reload_val = TW'(SHOW_CYCLES - 1);
      SHOW_GAP: reload_val = TW'(GAP_CYCLES - 1);
      WAIT_KEY: reload_val = TW'(TIMEOUT_CYCLES - 1);
      default:  reload_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      seq_r      <= '0;
      round      <= '0;
      index_r    <= '0;
      show_valid <= 1'b0;
      show_sym   <= '0;
      busy       <= 1'b0;
      win        <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      seq_r      <= seq_n;
      round      <= round_n;
      index_r    <= index_n;
      show_valid <= (state_n == SHOW_ON);
      show_sym   <= (state_n == SHOW_ON) ? sym_at(seq_n, index_n) : '0;
      busy       <= !(state_n inside {IDLE, WIN, FAIL});
      win        <= (state_n == WIN);
      fail       <= (state_n == FAIL);
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player: directed table, hand sequences and random games.
module tb_seq_player;

  localparam int S  = 3;
  localparam int G  = 2;
  localparam int TO = 20;
  localparam logic [17:0] SEQ_A = 18'b10_01_00_10_01_00_10_01_00;

  logic        clk = 1'b0;
  logic        reset_n, load, key_valid;
  logic [17:0] seq_in;
  logic [1:0]  key;
  logic        show_valid, busy, win, fail;
  logic [1:0]  show_sym;
  logic [3:0]  round;

  always #5 clk = ~clk;

  seq_player #(
    .SHOW_CYCLES    (S),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .seq_in     (seq_in),
    .key_valid  (key_valid),
    .key        (key),
    .show_valid (show_valid),
    .show_sym   (show_sym),
    .round      (round),
    .busy       (busy),
    .win        (win),
    .fail       (fail)
  );

  typedef struct {
    int          n;
    logic        ld;
    logic [17:0] seq;
    logic        kv;
    logic [1:0]  key;
    logic [9:0]  exp;
  } vec_t;

  vec_t        q[$];
  vec_t        tbl[16];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        p_ld, p_kv;
  logic [17:0] p_seq;
  logic [1:0]  p_key;
  logic [9:0]  last_e;

  // Expected output bundle: {show_valid, show_sym, round, busy, win, fail}
  function automatic logic [9:0] E(input int sv, input int sym, input int rnd,
                                   input int b, input int w, input int f);
    return {1'(sv), 2'(sym), 4'(rnd), 1'(b), 1'(w), 1'(f)};
  endfunction

  function automatic vec_t mk(input int n, input int ld, input logic [17:0] s,
                              input int kv, input int k, input logic [9:0] e);
    vec_t v;
    v.n = n; v.ld = 1'(ld); v.seq = s; v.kv = 1'(kv); v.key = 2'(k); v.exp = e;
    return v;
  endfunction

  function automatic logic [1:0] ref_sym(input logic [17:0] s, input int k);
    return 2'(s >> (2 * k));
  endfunction

  function automatic logic [9:0] dut_outs();
    return {show_valid, show_sym, round, busy, win, fail};
  endfunction

  function automatic int pick_delay();
    case ($urandom_range(0, 3))
      0:       return 18;
      1:       return 19;
      default: return int'($urandom_range(0, 19));
    endcase
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (show_valid,show_sym,round,busy,win,fail)",
               name, act, exp);
    end
  endtask

  // noise: 0 none, 1 ignored key pulses, 2 ignored key and load pulses
  task automatic push(input logic [9:0] e, input int noise);
    vec_t v;
    v = mk(1, int'(p_ld), p_seq, int'(p_kv), int'(p_key), e);
    if (!p_ld && !p_kv) begin
      if (noise >= 1 && $urandom_range(0, 7) == 0) begin
        v.kv  = 1'b1;
        v.key = 2'($urandom_range(0, 3));
      end
      if (noise == 2 && $urandom_range(0, 7) == 0) begin
        v.ld  = 1'b1;
        v.seq = 18'($urandom);
      end
    end
    q.push_back(v);
    p_ld   = 1'b0;
    p_kv   = 1'b0;
    last_e = e;
  endtask

  task automatic run_q(input string tag);
    foreach (q[i]) begin
      repeat (q[i].n) begin
        @(negedge clk);
        load      = q[i].ld;
        seq_in    = q[i].seq;
        key_valid = q[i].kv;
        key       = q[i].key;
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d]", tag, i), dut_outs(), q[i].exp);
      end
    end
    q.delete();
    @(negedge clk);
    load      = 1'b0;
    key_valid = 1'b0;
  endtask

  // mode 0: all keys correct; 1: wrong key at (fr,fj); 2: timeout at (fr,fj)
  task automatic gen_game(input logic [17:0] s, input int mode, input int fr, input int fj,
                          input logic [1:0] wk, input int fixd);
    bit         done;
    logic [1:0] sy;
    logic [9:0] wt;
    int         d;
    p_ld  = 1'b1;
    p_seq = s;
    done  = 0;
    for (int r = 0; r < 9 && !done; r++) begin
      for (int i = 0; i <= r; i++) begin
        repeat (S) push(E(1, int'(ref_sym(s, i)), r, 1, 0, 0), 2);
        repeat (G) push(E(0, 0, r, 1, 0, 0), 2);
      end
      wt = E(0, 0, r, 1, 0, 0);
      push(wt, 0);
      for (int j = 0; j <= r && !done; j++) begin
        sy = ref_sym(s, j);
        d  = (fixd >= 0) ? fixd : pick_delay();
        if (mode == 2 && r == fr && j == fj) begin
          repeat (TO - 1) push(wt, 0);
          push(E(0, 0, r, 0, 0, 1), 0);
          done = 1;
        end else begin
          repeat (d) push(wt, 0);
          p_kv = 1'b1;
          if (mode == 1 && r == fr && j == fj) begin
            p_key = (wk != sy) ? wk : (sy ^ 2'd1);
            push(E(0, 0, r, 0, 0, 1), 0);
            done = 1;
          end else if (sy == 2'd3) begin
            p_key = 2'($urandom_range(0, 3));
            push(E(0, 0, r, 0, 0, 1), 0);
            done = 1;
          end else begin
            p_key = sy;
            if (j < r) push(wt, 0);
            else if (r == 8) begin
              push(E(0, 0, 8, 0, 1, 0), 0);
              done = 1;
            end
          end
        end
      end
    end
    repeat (3) push(last_e, 1);
  endtask

  initial begin
    logic [17:0] s;
    int          mode, fr;
    reset_n = 1'b1; load = 1'b0; key_valid = 1'b0; seq_in = '0; key = '0;
    p_ld = 1'b0; p_kv = 1'b0; p_seq = '0; p_key = '0; last_e = '0;

    #1 reset_n = 1'b0;
    #1 check("reset_async", dut_outs(), '0);
    repeat (2) @(posedge clk);
    #1 check("reset_held", dut_outs(), '0);
    @(negedge clk) reset_n = 1'b1;

    tbl[0]  = mk(1, 1, 18'h0,     0, 0, E(1, 0, 0, 1, 0, 0));
    tbl[1]  = mk(1, 0, 18'h0,     1, 0, E(1, 0, 0, 1, 0, 0));
    tbl[2]  = mk(1, 1, 18'h3ffff, 0, 0, E(1, 0, 0, 1, 0, 0));
    tbl[3]  = mk(3, 0, 18'h0,     0, 0, E(0, 0, 0, 1, 0, 0));
    tbl[4]  = mk(1, 0, 18'h0,     1, 3, E(0, 0, 0, 0, 0, 1));
    tbl[5]  = mk(1, 0, 18'h0,     1, 0, E(0, 0, 0, 0, 0, 1));
    tbl[6]  = mk(1, 1, 18'h2,     0, 0, E(1, 2, 0, 1, 0, 0));
    tbl[7]  = mk(1, 0, 18'h2,     0, 0, E(1, 2, 0, 1, 0, 0));
    tbl[8]  = mk(1, 1, 18'h0,     0, 0, E(1, 2, 0, 1, 0, 0));
    tbl[9]  = mk(3, 0, 18'h0,     0, 0, E(0, 0, 0, 1, 0, 0));
    tbl[10] = mk(1, 0, 18'h0,     1, 2, E(1, 2, 1, 1, 0, 0));
    tbl[11] = mk(2, 0, 18'h0,     0, 0, E(1, 2, 1, 1, 0, 0));
    tbl[12] = mk(2, 0, 18'h0,     0, 0, E(0, 0, 1, 1, 0, 0));
    tbl[13] = mk(3, 0, 18'h0,     0, 0, E(1, 0, 1, 1, 0, 0));
    tbl[14] = mk(3, 0, 18'h0,     0, 0, E(0, 0, 1, 1, 0, 0));
    tbl[15] = mk(1, 0, 18'h0,     1, 1, E(0, 0, 1, 0, 0, 1));
    foreach (tbl[i]) q.push_back(tbl[i]);
    run_q("table");

    gen_game(SEQ_A, 0, 0, 0, 2'd0, -1);  run_q("win");
    gen_game(SEQ_A, 1, 2, 1, 2'd2, -1);  run_q("wrong_key_r2");
    gen_game(SEQ_A, 2, 0, 0, 2'd0, -1);  run_q("timeout_r0");
    gen_game(SEQ_A, 2, 3, 2, 2'd0, 18);  run_q("late_keys_timeout");
    gen_game(SEQ_A, 0, 0, 0, 2'd0, 19);  run_q("keys_at_expiry");

    @(negedge clk);
    load   = 1'b1;
    seq_in = 18'h2;
    @(posedge clk);
    #1 check("show_before_reset", dut_outs(), E(1, 2, 0, 1, 0, 0));
    load = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("reset_mid_show", dut_outs(), '0);
    @(negedge clk) reset_n = 1'b1;
    gen_game(SEQ_A, 1, 1, 0, 2'd3, -1);  run_q("after_reset");

    for (int g = 0; g < 12; g++) begin
      s = '0;
      for (int k = 0; k < 9; k++)
        s = s | (18'(($urandom_range(0, 11) == 0) ? 3 : $urandom_range(0, 2)) << (2 * k));
      mode = int'($urandom_range(0, 2));
      fr   = int'($urandom_range(0, 8));
      gen_game(s, mode, fr, int'($urandom_range(0, fr)), 2'($urandom_range(0, 3)), -1);
      run_q($sformatf("rand%0d", g));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
